// File: rtl/geofence_sorter_if.sv
// geofence_sorter_if: vertex capture/stream bus; the inside flag exists only with GEOFENCE_INSIDE_EN
interface geofence_sorter_if #(parameter int COORD_W = 8);
   logic give_valid;
   logic [COORD_W-1:0] dataX, dataY, ansX, ansY;
   logic out_valid, busy;
`ifdef GEOFENCE_INSIDE_EN
   logic inside;
   modport master (output give_valid, dataX, dataY, input ansX, ansY, out_valid, busy, inside);
   modport slave (input give_valid, dataX, dataY, output ansX, ansY, out_valid, busy, inside);
`else
   modport master (output give_valid, dataX, dataY, input ansX, ansY, out_valid, busy);
   modport slave (input give_valid, dataX, dataY, output ansX, ansY, out_valid, busy);
`endif
endinterface

// File: rtl/geofence_sorter.sv
// geofence_sorter: orders NUM_PTS vertices counter-clockwise about the first one and streams them out.
// Optional point-in-fence test for a trailing target vertex with GEOFENCE_INSIDE_EN.
module geofence_sorter #(
   parameter int NUM_PTS = 6,
   parameter int COORD_W = 8
) (
   input logic clk,
   input logic reset,
   geofence_sorter_if.slave bus
);
   localparam int SORT_CYC = (NUM_PTS-2)*(NUM_PTS-2);
`ifdef GEOFENCE_INSIDE_EN
   localparam int LOAD_N = NUM_PTS+1;
`else
   localparam int LOAD_N = NUM_PTS;
`endif
   localparam int CW = $clog2(LOAD_N);
   localparam int SW = $clog2(SORT_CYC+1);
   localparam int PW = 2*COORD_W+2;
   typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;
   state_t state, state_nx;
   logic [COORD_W-1:0] px [LOAD_N];
   logic [COORD_W-1:0] py [LOAD_N];
   logic [CW-1:0] cnt, nxt, j, jn;
   logic [SW-1:0] scnt;
   logic take, last_ld, swap;
   logic signed [COORD_W:0] dxi, dyi, dxj, dyj;
   logic signed [PW-1:0] m1, m2;
   logic signed [PW:0] cr;
   assign take = bus.give_valid && (state == IDLE || state == LOAD);
   assign last_ld = take && cnt == CW'(LOAD_N-1);
   assign jn = j + CW'(1);
   assign nxt = cnt == CW'(NUM_PTS-1) ? '0 : cnt + CW'(1);
   assign bus.busy = state == SORT || state == OUT;
   // i precedes j; a negative cross product means j lies clockwise of i
   assign dxi = $signed({1'b0, px[j]}) - $signed({1'b0, px[0]});
   assign dyi = $signed({1'b0, py[j]}) - $signed({1'b0, py[0]});
   assign dxj = $signed({1'b0, px[jn]}) - $signed({1'b0, px[0]});
   assign dyj = $signed({1'b0, py[jn]}) - $signed({1'b0, py[0]});
   assign m1 = dxi * dyj;
   assign m2 = dxj * dyi;
   assign cr = (PW+1)'(m1) - (PW+1)'(m2);
   assign swap = cr[PW];
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = take ? LOAD : IDLE;
         LOAD: state_nx = last_ld ? SORT : LOAD;
         SORT: state_nx = scnt == SW'(SORT_CYC-1) ? OUT : SORT;
         OUT: state_nx = cnt == CW'(NUM_PTS-1) ? IDLE : OUT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (take) begin
         px[cnt] <= bus.dataX;
         py[cnt] <= bus.dataY;
      end else if (state == SORT && swap) begin
         px[j] <= px[jn];
         px[jn] <= px[j];
         py[j] <= py[jn];
         py[jn] <= py[j];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         j <= CW'(1);
         scnt <= '0;
         bus.out_valid <= 1'b0;
         bus.ansX <= '0;
         bus.ansY <= '0;
      end else begin
         state <= state_nx;
         cnt <= take ? (last_ld ? '0 : cnt + CW'(1)) : (state == OUT ? nxt : cnt);
         j <= state == SORT ? (j == CW'(NUM_PTS-2) ? CW'(1) : jn) : CW'(1);
         scnt <= state == SORT ? scnt + SW'(1) : '0;
         bus.out_valid <= state == OUT;
         bus.ansX <= state == OUT ? px[cnt] : '0;
         bus.ansY <= state == OUT ? py[cnt] : '0;
      end
   end
`ifdef GEOFENCE_INSIDE_EN
   // target sits just past the fence vertices; edge k runs from P[k] to P[k+1 mod N]
   logic signed [COORD_W:0] ex, ey, tx, ty;
   logic signed [PW-1:0] m3, m4;
   logic signed [PW:0] ce;
   logic e, acc;
   assign ex = $signed({1'b0, px[nxt]}) - $signed({1'b0, px[cnt]});
   assign ey = $signed({1'b0, py[nxt]}) - $signed({1'b0, py[cnt]});
   assign tx = $signed({1'b0, px[NUM_PTS]}) - $signed({1'b0, px[cnt]});
   assign ty = $signed({1'b0, py[NUM_PTS]}) - $signed({1'b0, py[cnt]});
   assign m3 = ex * ty;
   assign m4 = ey * tx;
   assign ce = (PW+1)'(m3) - (PW+1)'(m4);
   assign e = !ce[PW] && ce != '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= 1'b0;
         bus.inside <= 1'b0;
      end else begin
         acc <= state == OUT ? (cnt == '0 ? e : acc && e) : 1'b0;
         bus.inside <= state == OUT && cnt == CW'(NUM_PTS-1) && acc && e;
      end
   end
`endif
endmodule

// File: tb/tb_geofence_sorter.sv
// tb_geofence_sorter: directed vectors for geofence_sorter; define GEOFENCE_INSIDE_EN to cover the inside test.
module tb_geofence_sorter;
   localparam int N = 6;
`ifdef GEOFENCE_INSIDE_EN
   localparam int LN = N+1;
`else
   localparam int LN = N;
`endif
   typedef logic [15:0] pt_t;
   typedef pt_t set_t [7];
   logic clk = 1'b0;
   logic reset = 1'b1;
   geofence_sorter_if #(.COORD_W(8)) bus ();
   geofence_sorter #(.NUM_PTS(N), .COORD_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int tests = 0, fails = 0, cyc = 0, zero_bad = 0, beat = 0, last_edge = 0;
   pt_t got[$], gold[$];
   int first_q[$], edge_q[$];
`ifdef GEOFENCE_INSIDE_EN
   int in_bad = 0;
   logic last_inside = 1'b0;
`endif
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (reset) beat = 0;
      if (bus.out_valid) begin
         if (beat == 0) first_q.push_back(cyc);
         got.push_back({bus.ansX, bus.ansY});
`ifdef GEOFENCE_INSIDE_EN
         if (beat == N-1) last_inside = bus.inside;
         else if (bus.inside) in_bad++;
`endif
         beat = (beat == N-1) ? 0 : beat + 1;
      end else begin
         if (bus.ansX != 0 || bus.ansY != 0) zero_bad++;
`ifdef GEOFENCE_INSIDE_EN
         if (bus.inside) in_bad++;
`endif
      end
   end
   function automatic pt_t pt(input int x, input int y);
      return {x[7:0], y[7:0]};
   endfunction
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic send_set(input set_t s, input int gap_at, input int gap_len);
      for (int i = 0; i < LN; i++) begin
         bus.give_valid = 1'b1;
         {bus.dataX, bus.dataY} = s[i];
         @(negedge clk);
         if (i == gap_at) begin
            bus.give_valid = 1'b0;
            repeat (gap_len) @(negedge clk);
         end
      end
      bus.give_valid = 1'b0;
      last_edge = cyc;
   endtask
   task automatic expect_set(input set_t g);
      for (int i = 0; i < N; i++) gold.push_back(g[i]);
      edge_q.push_back(last_edge);
   endtask
   task automatic wait_done();
      int n = 0;
      while (!(bus.out_valid && !bus.busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_in_time", n < 200, 1);
   endtask
   task automatic compare(input string tag);
      check({tag, "_beats"}, got.size(), gold.size());
      for (int i = 0; i < gold.size() && i < got.size(); i++) check(tag, got[i], gold[i]);
      check({tag, "_sets"}, first_q.size(), edge_q.size());
      for (int i = 0; i < first_q.size() && i < edge_q.size(); i++)
         check({tag, "_lat"}, first_q[i] - edge_q[i], 17);
      got.delete();
      gold.delete();
      first_q.delete();
      edge_q.delete();
   endtask
   initial begin
      set_t s2, g2, scol, gcol, s3, g3;
      s2 = '{pt(10,10), pt(30,10), pt(10,30), pt(30,30), pt(20,5), pt(5,20), pt(18,18)};
      g2 = '{pt(10,10), pt(20,5), pt(30,10), pt(30,30), pt(10,30), pt(5,20), pt(18,18)};
      scol = '{pt(10,10), pt(10,30), pt(30,10), pt(20,10), pt(30,30), pt(5,20), pt(18,18)};
      gcol = '{pt(10,10), pt(30,10), pt(20,10), pt(30,30), pt(10,30), pt(5,20), pt(18,18)};
      s3 = '{pt(50,50), pt(60,70), pt(80,50), pt(40,60), pt(70,40), pt(50,80), pt(55,55)};
      g3 = '{pt(50,50), pt(70,40), pt(80,50), pt(60,70), pt(50,80), pt(40,60), pt(55,55)};
      bus.give_valid = 1'b0;
      bus.dataX = '0;
      bus.dataY = '0;
      repeat (3) begin
         @(negedge clk);
         check("t1_reset", {bus.out_valid, bus.busy, bus.ansX, bus.ansY}, 0);
      end
      reset = 1'b0;
      @(negedge clk);
      send_set(s2, -1, 0);
      expect_set(g2);
      check("t2_busy_sort", bus.busy, 1);
      wait_done();
      @(negedge clk);
      check("t2_busy_after", bus.busy, 0);
      compare("t2");
      send_set(s2, 1, 3);
      expect_set(g2);
      bus.give_valid = 1'b1;
      {bus.dataX, bus.dataY} = pt(99, 99);
      repeat (4) @(negedge clk);
      bus.give_valid = 1'b0;
      wait_done();
      @(negedge clk);
      compare("t3");
      send_set(g2, -1, 0);
      expect_set(g2);
      wait_done();
      send_set(scol, -1, 0);
      expect_set(gcol);
      wait_done();
      send_set(s3, -1, 0);
      expect_set(g3);
      wait_done();
      @(negedge clk);
      compare("t4");
      send_set(s2, -1, 0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      send_set(s3, -1, 0);
      expect_set(g3);
      wait_done();
      @(negedge clk);
      compare("t5");
`ifdef GEOFENCE_INSIDE_EN
      s2[6] = pt(18, 18);
      send_set(s2, -1, 0);
      expect_set(g2);
      wait_done();
      @(negedge clk);
      check("t6_in_1818", last_inside, 1);
      s2[6] = pt(40, 40);
      send_set(s2, -1, 0);
      expect_set(g2);
      wait_done();
      @(negedge clk);
      check("t6_in_4040", last_inside, 0);
      s2[6] = pt(30, 20);
      send_set(s2, -1, 0);
      expect_set(g2);
      wait_done();
      @(negedge clk);
      check("t6_in_edge", last_inside, 0);
      compare("t6");
      check("t6_inside_only_last", in_bad, 0);
`endif
      check("zero_when_idle", zero_bad, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
